// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter driving a sequence-detector input, MSB first.
// Optional back-to-back frame repeat when SEQ_TX_REPEAT_EN is defined.
module seq_pattern_tx #(
  parameter int         WIDTH      = 16,
  parameter logic       IDLE_LEVEL = 1'b0,
  localparam int        LW         = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LW-1:0]    len,
  input  logic             repeat_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LW-1:0] WL  = LW'(WIDTH);
  localparam logic [LW-1:0] ONE = LW'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] frame, frame_n;
  logic [LW-1:0]    cnt, cnt_n;
  logic [LW-1:0]    eff_len;
  logic             x_n, xv_n, done_n;

  // out-of-range lengths fall back to a full-width frame
  assign eff_len = (len == '0 || len > WL) ? WL : len;
  assign busy    = (state != IDLE);

`ifdef SEQ_TX_REPEAT_EN
  logic [LW-1:0] flen, flen_n;
`else
  logic unused_rep;
  assign unused_rep = ^{repeat_en, frame};
`endif

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    frame_n = frame;
    cnt_n   = cnt;
    x_n     = x;
    xv_n    = x_valid;
    done_n  = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
    flen_n  = flen;
`endif
    unique case (state)
      IDLE: begin
        x_n  = IDLE_LEVEL;
        xv_n = 1'b0;
        if (start) begin
          sreg_n  = data_in;
          frame_n = data_in;
          cnt_n   = eff_len - ONE;
`ifdef SEQ_TX_REPEAT_EN
          flen_n  = eff_len - ONE;
`endif
          x_n     = data_in[WIDTH-1];
          xv_n    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sreg_n = sreg << 1;
          x_n    = sreg[WIDTH-2];
          xv_n   = 1'b1;
          cnt_n  = cnt - ONE;
        end else begin
`ifdef SEQ_TX_REPEAT_EN
          if (repeat_en) begin
            done_n = 1'b1;
            sreg_n = frame;
            cnt_n  = flen;
            x_n    = frame[WIDTH-1];
            xv_n   = 1'b1;
          end else
`endif
          begin
            x_n     = IDLE_LEVEL;
            xv_n    = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        x_n     = IDLE_LEVEL;
        xv_n    = 1'b0;
        state_n = IDLE;
      end
      default: begin
        x_n     = IDLE_LEVEL;
        xv_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      frame   <= '0;
      cnt     <= '0;
      x       <= IDLE_LEVEL;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      frame   <= frame_n;
      cnt     <= cnt_n;
      x       <= x_n;
      x_valid <= xv_n;
      done    <= done_n;
    end
  end

`ifdef SEQ_TX_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flen <= '0;
    else        flen <= flen_n;
  end
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx (default build, repeat disabled).
module tb_seq_pattern_tx;

  localparam int   WIDTH = 16;
  localparam int   LW    = $clog2(WIDTH) + 1;
  localparam logic IDLE  = 1'b0;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [LW-1:0]    len = '0;
  logic             repeat_en = 1'b0;
  logic             x, x_valid, busy, done;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;
  logic exp_q[$];

  seq_pattern_tx #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .data_in(data_in), .len(len), .repeat_en(repeat_en),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] d,
                            input logic [LW-1:0] l);
    int n;
    n = (l == 0 || l > WIDTH) ? WIDTH : int'(l);
    for (int i = 0; i < n; i++) exp_q.push_back(d[WIDTH-1-i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (x_valid) begin
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else chk("x_bit", x, exp_q.pop_front());
    end else begin
      chk("x_idle", x, IDLE);
    end
    if (done) n_done++;
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] d,
                           input logic [LW-1:0] l);
    bit seen;
    start   = 1'b1;
    data_in = d;
    len     = l;
    push_frame(d, l);
    step();
    start   = 1'b0;
    data_in = WIDTH'($urandom);
    len     = LW'($urandom);
    chk("first_valid", x_valid, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) begin
        seen = 1;
        break;
      end
      chk("contig", x_valid, 1);
    end
    chk("done_seen", seen, 1);
    chk("q_empty", exp_q.size(), 0);
    chk("valid_at_done", x_valid, 0);
    chk("busy_at_done", busy, 1);
    step();
    chk("done_1cyc", done, 0);
    chk("busy_low", busy, 0);
  endtask

  logic [14:0] vpat, dpat;
  int          d0;

  initial begin
    #6;
    chk("rst_x", x, IDLE);
    chk("rst_valid", x_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #6;
    reset = 1'b1;

    run_frame(16'b0001111000111001, 0);
    run_frame(16'hA000, 4);

    // held start: 3-bit frames with two idle cycles between them
    start   = 1'b1;
    data_in = 16'hFFFF;
    len     = 3;
    for (int i = 0; i < 9; i++) exp_q.push_back(1'b1);
    for (int i = 14; i >= 0; i--) begin
      step();
      vpat[i] = x_valid;
      dpat[i] = done;
    end
    start = 1'b0;
    chk("held_valid", vpat, 15'b111001110011100);
    chk("held_done", dpat, 15'b000100001000010);
    chk("held_q", exp_q.size(), 0);
    step();
    step();
    chk("held_idle", busy, 0);

    // asynchronous abort after the fifth bit
    start   = 1'b1;
    data_in = 16'hFFFF;
    len     = 0;
    push_frame(16'hFFFF, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_abort", x_valid, 1);
    d0 = n_done;
    #3;
    reset = 1'b0;
    #1;
    chk("abort_x", x, IDLE);
    chk("abort_valid", x_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("abort_no_done", n_done, d0);
    run_frame(16'h5A3C, 0);

    run_frame(16'h8001, 1);
    run_frame(16'h8001, LW'(WIDTH + 5));
    run_frame(16'hC3A5, LW'(WIDTH));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001: Parameter WIDTH, default 16, SHALL set the frame register width in bits (legal range 2..32).
REQ-002: Parameter IDLE_LEVEL, default 1'b0, SHALL set the level driven on x when no frame bit is being sent.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset (asserted when 0).
REQ-005: start  input  1  SHALL request transmission of data_in; sampled only in IDLE.
REQ-006: data_in  input  WIDTH  SHALL be the frame to send, MSB first.
REQ-007: len  input  $clog2(WIDTH)+1  SHALL give the number of bits to send from the MSB down; 0 or any value >WIDTH SHALL mean WIDTH.
REQ-008: repeat_en  input  1  SHALL request back-to-back retransmission of the captured frame (active only with SEQ_TX_REPEAT_EN).
REQ-009: x  output  1  SHALL be the registered serial bit stream feeding the sequence detector input.
REQ-010: x_valid  output  1  SHALL be high exactly on cycles where x carries a frame bit.
REQ-011: busy  output  1  SHALL be high while the state is not IDLE.
REQ-012: done  output  1  SHALL pulse high for exactly one cycle after the last bit of each frame.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014: In IDLE with start=1 at edge k, the block SHALL capture data_in into the shift register and frame register, load the bit counter with the effective len minus 1, drive x=data_in[WIDTH-1], set x_valid=1 and go to SHIFT, all at edge k (latency one edge from start to the first bit).
REQ-015: In SHIFT with counter>0, each edge SHALL shift left by one, drive x with the next MSB, keep x_valid=1 and decrement the counter.
REQ-016: In SHIFT with counter=0, the edge SHALL drive x=IDLE_LEVEL, x_valid=0, done=1 and go to DONE; a frame of N bits occupies exactly N consecutive x_valid cycles.
REQ-017: In DONE, the next edge SHALL clear done and return to IDLE; start is ignored in DONE, so the minimum gap between frames is 2 cycles.
REQ-018: start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued; data_in/len changes after capture SHALL NOT affect the frame in flight.
REQ-019: len=1 SHALL send only the MSB: one x_valid cycle, then the DONE pulse.
REQ-020: In IDLE and DONE, x SHALL equal IDLE_LEVEL.

Reset
REQ-021: reset=0 SHALL immediately force state=IDLE, x=IDLE_LEVEL, x_valid=0, busy=0, done=0, shift register, frame register and counter=0, independent of clk.
REQ-022: reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the first start SHALL begin a fresh frame per REQ-014.

Configuration
REQ-023: With macro SEQ_TX_REPEAT_EN defined, if repeat_en=1 at the edge where the last bit completes (counter=0 in SHIFT), the block SHALL pulse done, reload the shift register from the frame register and counter from the captured len, and drive the captured MSB on x with x_valid=1 on that same edge, with no gap bit and state remaining SHIFT.
REQ-024: With SEQ_TX_REPEAT_EN undefined, repeat_en SHALL be ignored and behaviour SHALL be exactly REQ-013..REQ-020.

Verification
REQ-025: reset=0 for 12 ns, then data_in=16'b0001111000111001, len=0, one-cycle start -> x reproduces 0,0,0,1,1,1,1,0,0,0,1,1,1,0,0,1 on 16 consecutive x_valid cycles; done pulses once on the following cycle.
REQ-026: len=4, data_in=16'hA000 -> x=1,0,1,0 on 4 x_valid cycles; then x=IDLE_LEVEL, done for 1 cycle, busy low 2 cycles after the last bit.
REQ-027: start held high continuously with data_in=16'hFFFF, len=3 -> frames of 3 ones separated by exactly 2 non-valid cycles; start during SHIFT produces no extra frame.
REQ-028: reset pulsed low after the 5th bit of a 16-bit frame -> outputs go to reset values without waiting for clk, no done pulse; a subsequent start sends the full new frame.
REQ-029: With SEQ_TX_REPEAT_EN defined, repeat_en=1, data_in=16'hC000, len=2 -> x=1,1,1,1,... with x_valid continuously high and done pulsing every 2nd cycle; repeat_en=0 ends after the current frame.
REQ-030: len=1 and len=WIDTH+5 with data_in=16'h8001 -> one bit (1), and a full 16-bit frame respectively.
